// File: rtl/memory_port_arbiter.sv
// Arbiter sharing one memory port between IF fetches and MEM loads/stores.
// Define ARB_FAIRNESS_EN to bound IF starvation with a grant counter.
module memory_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                ifReq,
    input  logic [ADDR_W-1:0]   ifAddr,
    input  logic                ifKill,
    output logic                ifValid,
    output logic [DATA_W-1:0]   ifRdata,
    output logic                ifStall,
    input  logic                dReq,
    input  logic                dWe,
    input  logic [ADDR_W-1:0]   dAddr,
    input  logic [DATA_W-1:0]   dWdata,
    input  logic [DATA_W/8-1:0] dBe,
    output logic                dValid,
    output logic [DATA_W-1:0]   dRdata,
    output logic                dStall,
    output logic                memReq,
    output logic                memWe,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    output logic [DATA_W/8-1:0] memBe,
    input  logic                memDone,
    input  logic [DATA_W-1:0]   memRdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        DRAIN
    } state_t;

    state_t state;
    logic   if_wins;
    logic   grant_if;
    logic   grant_d;

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // A saturated counter means IF has waited long enough to beat MEM.
    assign if_wins = ifReq & (~dReq | (starve_cnt == CNT_MAX));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && ifReq && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign if_wins = ifReq & ~dReq;
`endif

    assign grant_if = (state == IDLE) & if_wins;
    assign grant_d  = (state == IDLE) & dReq & ~if_wins;

    assign ifStall = ifReq & ~ifValid;
    assign dStall  = dReq & ~dValid;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memBe    <= '0;
            ifValid  <= 1'b0;
            ifRdata  <= '0;
            dValid   <= 1'b0;
            dRdata   <= '0;
        end else begin
            ifValid <= 1'b0;
            dValid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= BUSY_D;
                        memReq   <= 1'b1;
                        memWe    <= dWe;
                        memAddr  <= dAddr;
                        memWdata <= dWdata;
                        memBe    <= dWe ? dBe : '1;
                    end else if (grant_if) begin
                        state    <= BUSY_IF;
                        memReq   <= 1'b1;
                        memWe    <= 1'b0;
                        memAddr  <= ifAddr;
                        memWdata <= '0;
                        memBe    <= '1;
                    end
                end
                BUSY_IF: begin
                    if (memDone) begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                        // A kill landing with the response drops it.
                        if (!ifKill) begin
                            ifValid <= 1'b1;
                            ifRdata <= memRdata;
                        end
                    end else if (ifKill) begin
                        state <= DRAIN;
                    end
                end
                BUSY_D: begin
                    if (memDone) begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        dValid <= 1'b1;
                        if (!memWe) begin
                            dRdata <= memRdata;
                        end
                    end
                end
                DRAIN: begin
                    if (memDone) begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios, then random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_memory_port_arbiter;

    localparam int STARVE = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifKill;
    logic        ifValid;
    logic [63:0] ifRdata;
    logic        ifStall;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [63:0] dWdata;
    logic [7:0]  dBe;
    logic        dValid;
    logic [63:0] dRdata;
    logic        dStall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [63:0] memWdata;
    logic [7:0]  memBe;
    logic        memDone;
    logic [63:0] memRdata;

    memory_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(64),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .ifReq(ifReq),
        .ifAddr(ifAddr),
        .ifKill(ifKill),
        .ifValid(ifValid),
        .ifRdata(ifRdata),
        .ifStall(ifStall),
        .dReq(dReq),
        .dWe(dWe),
        .dAddr(dAddr),
        .dWdata(dWdata),
        .dBe(dBe),
        .dValid(dValid),
        .dRdata(dRdata),
        .dStall(dStall),
        .memReq(memReq),
        .memWe(memWe),
        .memAddr(memAddr),
        .memWdata(memWdata),
        .memBe(memBe),
        .memDone(memDone),
        .memRdata(memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one outstanding transaction and who owns it.
    // owner: 0 = fetch, 1 = load/store, 2 = killed fetch.
    bit          m_busy;
    int          m_owner;
    bit          m_we;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    bit          m_ifv;
    bit          m_dv;
    logic [63:0] m_ifr;
    logic [63:0] m_dr;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_we    = 0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        m_ifv   = 0;
        m_dv    = 0;
        m_ifr   = '0;
        m_dr    = '0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        bit nifv;
        bit ndv;
        bit pick_if;
        bit was_we;
        nifv = 0;
        ndv  = 0;
        if (!rstN) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (ifReq || dReq) begin
                pick_if = ifReq && (!dReq || (FAIR && m_cnt == STARVE));
                m_busy  = 1;
                if (pick_if) begin
                    m_owner = 0;
                    m_we    = 0;
                    m_addr  = ifAddr;
                    m_be    = 8'hFF;
                    m_cnt   = 0;
                end else begin
                    m_owner = 1;
                    m_we    = dWe;
                    m_addr  = dAddr;
                    m_wdata = dWdata;
                    m_be    = dWe ? dBe : 8'hFF;
                    if (ifReq && m_cnt < STARVE) m_cnt++;
                end
            end
        end else if (memDone) begin
            m_busy = 0;
            was_we = m_we;
            m_we   = 0;
            if (m_owner == 0 && !ifKill) begin
                nifv  = 1;
                m_ifr = memRdata;
            end
            if (m_owner == 1) begin
                ndv = 1;
                if (!was_we) m_dr = memRdata;
            end
        end else if (m_owner == 0 && ifKill) begin
            m_owner = 2;
        end
        m_ifv = nifv;
        m_dv  = ndv;
    endtask

    task automatic check_outputs();
        chk("memReq", 64'(memReq), 64'(m_busy));
        chk("memWe", 64'(memWe), 64'(m_we));
        chk("ifValid", 64'(ifValid), 64'(m_ifv));
        chk("dValid", 64'(dValid), 64'(m_dv));
        chk("ifRdata", ifRdata, m_ifr);
        chk("dRdata", dRdata, m_dr);
        chk("ifStall", 64'(ifStall), 64'(ifReq & ~m_ifv));
        chk("dStall", 64'(dStall), 64'(dReq & ~m_dv));
        if (m_busy) begin
            chk("memAddr", 64'(memAddr), 64'(m_addr));
            chk("memBe", 64'(memBe), 64'(m_be));
            if (m_we) chk("memWdata", memWdata, m_wdata);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic reset_checks();
        chk("rst memReq", 64'(memReq), 64'd0);
        chk("rst memWe", 64'(memWe), 64'd0);
        chk("rst ifValid", 64'(ifValid), 64'd0);
        chk("rst dValid", 64'(dValid), 64'd0);
        chk("rst memAddr", 64'(memAddr), 64'd0);
        chk("rst memWdata", memWdata, 64'd0);
        chk("rst memBe", 64'(memBe), 64'd0);
        chk("rst ifRdata", ifRdata, 64'd0);
        chk("rst dRdata", dRdata, 64'd0);
    endtask

    // Asserts reset between edges, checks it took effect immediately.
    task automatic do_reset();
        rstN = 1'b0;
        #1;
        model_reset();
        reset_checks();
        cycle();
        cycle();
        rstN = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_addr;
        rstN     = 1'b0;
        ifReq    = 1'b0;
        ifAddr   = '0;
        ifKill   = 1'b0;
        dReq     = 1'b0;
        dWe      = 1'b0;
        dAddr    = '0;
        dWdata   = '0;
        dBe      = '0;
        memDone  = 1'b0;
        memRdata = '0;
        model_reset();
        #2;
        reset_checks();
        cycle();
        rstN = 1'b1;
        cycle();

        // Reset in the middle of a load, then a fetch right after release.
        dReq  = 1'b1;
        dAddr = 32'h3000;
        cycle();
        chk("busy_d memReq", 64'(memReq), 64'd1);
        dReq = 1'b0;
        do_reset();
        ifReq  = 1'b1;
        ifAddr = 32'h100;
        cycle();
        chk("post-rst memReq", 64'(memReq), 64'd1);
        chk("post-rst memAddr", 64'(memAddr), 64'h100);
        memDone  = 1'b1;
        memRdata = 64'h0123;
        cycle();
        chk("post-rst ifValid", 64'(ifValid), 64'd1);
        ifReq   = 1'b0;
        memDone = 1'b0;
        cycle();

        // Both requesters at once: MEM first, fetch two cycles later.
        ifReq  = 1'b1;
        ifAddr = 32'h500;
        dReq   = 1'b1;
        dWe    = 1'b0;
        dAddr  = 32'h2000;
        cycle();
        chk("prio first addr", 64'(memAddr), 64'h2000);
        memDone  = 1'b1;
        memRdata = 64'hDEADBEEF;
        cycle();
        chk("prio dValid", 64'(dValid), 64'd1);
        chk("prio dRdata", dRdata, 64'hDEADBEEF);
        dReq    = 1'b0;
        memDone = 1'b0;
        cycle();
        chk("prio second addr", 64'(memAddr), 64'h500);
        memDone  = 1'b1;
        memRdata = 64'h5555;
        cycle();
        chk("prio ifValid", 64'(ifValid), 64'd1);
        ifReq   = 1'b0;
        memDone = 1'b0;
        cycle();

        // Kill a fetch in flight; its late response must vanish.
        ifReq  = 1'b1;
        ifAddr = 32'h40;
        cycle();
        ifKill = 1'b1;
        ifReq  = 1'b0;
        cycle();
        chk("drain memReq", 64'(memReq), 64'd1);
        ifKill = 1'b0;
        cycle();
        memDone  = 1'b1;
        memRdata = 64'hBAD0;
        cycle();
        chk("drain ifValid", 64'(ifValid), 64'd0);
        chk("drain idle", 64'(memReq), 64'd0);
        memDone = 1'b0;
        cycle();

        // Kill and completion in the same cycle.
        ifReq  = 1'b1;
        ifAddr = 32'h60;
        cycle();
        ifKill  = 1'b1;
        memDone = 1'b1;
        ifReq   = 1'b0;
        cycle();
        chk("kill+done ifValid", 64'(ifValid), 64'd0);
        chk("kill+done memReq", 64'(memReq), 64'd0);
        ifKill  = 1'b0;
        memDone = 1'b0;
        cycle();

        // Store: strobes held for the whole access, dRdata untouched.
        dReq   = 1'b1;
        dWe    = 1'b1;
        dAddr  = 32'h80;
        dBe    = 8'h0F;
        dWdata = 64'h11223344;
        cycle();
        cycle();
        chk("store memWe", 64'(memWe), 64'd1);
        chk("store memBe", 64'(memBe), 64'h0F);
        memDone  = 1'b1;
        memRdata = 64'hFFFF;
        cycle();
        chk("store dValid", 64'(dValid), 64'd1);
        chk("store dRdata", dRdata, 64'hDEADBEEF);
        dReq    = 1'b0;
        dWe     = 1'b0;
        memDone = 1'b0;
        cycle();

        // Both held high: grant order follows the starvation rule.
        do_reset();
        ifReq  = 1'b1;
        ifAddr = 32'h100;
        dReq   = 1'b1;
        dAddr  = 32'h200;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            exp_addr = (FAIR && (k % (STARVE + 1) == 0)) ? 32'h100 : 32'h200;
            chk($sformatf("fair grant %0d", k), 64'(memAddr), 64'(exp_addr));
            memDone  = 1'b1;
            memRdata = 64'(k);
            cycle();
            memDone = 1'b0;
        end
        ifReq = 1'b0;
        dReq  = 1'b0;
        cycle();
        cycle();

        // Random traffic with random latency, kills and resets.
        for (int i = 0; i < 4000; i++) begin
            memDone  = ($urandom_range(2) == 0);
            memRdata = {$urandom, $urandom};
            ifKill   = 1'b0;
            if (ifReq && m_ifv) begin
                ifReq  = $urandom_range(1);
                ifAddr = $urandom & 32'hFFF8;
            end else if (!ifReq) begin
                ifReq  = ($urandom_range(2) == 0);
                ifAddr = $urandom & 32'hFFF8;
            end else if ($urandom_range(9) == 0) begin
                ifKill = 1'b1;
                ifReq  = $urandom_range(1);
                ifAddr = $urandom & 32'hFFF8;
            end
            if (!dReq || m_dv) begin
                dReq   = ($urandom_range(3) == 0);
                dWe    = $urandom_range(1);
                dAddr  = $urandom;
                dWdata = {$urandom, $urandom};
                dBe    = 8'($urandom);
            end
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
